// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the time-shared serial pattern detector.
//   engine_e  : engine mode (RUN / HOLD / CLEAR), derived every cycle from en/clr
//   Def*      : default channel count, pattern length and pattern
//   ch_w()    : width of a channel index for a given channel count
package seq_det_pkg;

    typedef enum logic [1:0] {
        EngRun,
        EngHold,
        EngClear
    } engine_e;

    localparam int unsigned DefNumCh  = 4;
    localparam int unsigned DefPatLen = 4;
    localparam logic [3:0]  DefPattern = 4'b1011;

    function automatic int unsigned ch_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above ptr_i, wrapping.
//   req_i     : per-channel request
//   ptr_i     : highest-priority channel this cycle
//   en_i      : when low no grant is issued
//   gnt_o     : one-hot grant (all-zero when nothing is granted)
//   gnt_id_o  : encoded id of the granted channel (0 when none)
//   gnt_any_o : a grant was issued
module rr_arbiter
    import seq_det_pkg::*;
#(
    parameter int unsigned NUM_CH = DefNumCh,
    localparam int unsigned CH_W  = ch_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CH_W-1:0]   ptr_i,
    input  logic              en_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic [CH_W-1:0]   gnt_id_o,
    output logic              gnt_any_o
);

    always_comb begin
        logic [CH_W-1:0] idx;
        gnt_o     = '0;
        gnt_id_o  = '0;
        gnt_any_o = 1'b0;
        idx       = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            idx = CH_W'((32'(ptr_i) + k) % NUM_CH);
            if (en_i && !gnt_any_o && req_i[idx]) begin
                gnt_any_o = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_id_o  = idx;
            end
        end
    end

endmodule

// File: rtl/seq_det_sched.sv
// One serial pattern detector time-shared among NUM_CH bit-stream channels.
// Each channel keeps its own history and fill count, so detection per channel
// (including overlapping matches) behaves as if it had a dedicated detector.
//   clk, nrst    : clock, asynchronous active-low reset
//   en_i         : engine enable (low: no transfers, state holds)
//   clr_i        : synchronous clear of contexts, counters and rr pointer
//   ch_valid_i   : per-channel bit available
//   ch_bit_i     : per-channel serial bit
//   ch_ready_o   : one-hot grant; transfer where valid & ready
//   det_valid_o  : one-cycle pulse, match completed on the previous transfer
//   det_ch_o     : channel of the latest match (held)
//   match_cnt_o  : packed saturating per-channel match counters
module seq_det_sched
    import seq_det_pkg::*;
#(
    parameter int unsigned         NUM_CH  = DefNumCh,
    parameter int unsigned         PAT_LEN = DefPatLen,
    parameter logic [PAT_LEN-1:0]  PATTERN = DefPattern,
    parameter int unsigned         CNT_W   = 8,
    localparam int unsigned        CH_W    = ch_w(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    en_i,
    input  logic                    clr_i,
    input  logic [NUM_CH-1:0]       ch_valid_i,
    input  logic [NUM_CH-1:0]       ch_bit_i,
    output logic [NUM_CH-1:0]       ch_ready_o,
    output logic                    det_valid_o,
    output logic [CH_W-1:0]         det_ch_o,
    output logic [NUM_CH*CNT_W-1:0] match_cnt_o
);

    localparam int unsigned        FILL_W   = $clog2(PAT_LEN);
    localparam logic [FILL_W-1:0]  FILL_MAX = FILL_W'(PAT_LEN - 1);

    engine_e engine;

    logic [PAT_LEN-2:0] hist_q [NUM_CH];
    logic [PAT_LEN-2:0] hist_d [NUM_CH];
    logic [FILL_W-1:0]  fill_q [NUM_CH];
    logic [FILL_W-1:0]  fill_d [NUM_CH];
    logic [CNT_W-1:0]   cnt_q  [NUM_CH];
    logic [CNT_W-1:0]   cnt_d  [NUM_CH];
    logic [CH_W-1:0]    ptr_q, ptr_d;
    logic               det_valid_q, det_valid_d;
    logic [CH_W-1:0]    det_ch_q, det_ch_d;

    logic [NUM_CH-1:0]  gnt;
    logic [CH_W-1:0]    gnt_id;
    logic               xfer;
    logic [PAT_LEN-1:0] cand;
    logic               match;

    always_comb begin
        if (clr_i) begin
            engine = EngClear;
        end else if (!en_i) begin
            engine = EngHold;
        end else begin
            engine = EngRun;
        end
    end

    // nrst gates the grant so ch_ready stays low throughout reset
    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .req_i     (ch_valid_i),
        .ptr_i     (ptr_q),
        .en_i      ((engine == EngRun) && nrst),
        .gnt_o     (gnt),
        .gnt_id_o  (gnt_id),
        .gnt_any_o (xfer)
    );

    assign ch_ready_o = gnt;

    // The fill check stops zero-initialised history from faking a match
    // when the pattern begins with zeros.
    assign cand  = {hist_q[gnt_id], ch_bit_i[gnt_id]};
    assign match = xfer && (fill_q[gnt_id] == FILL_MAX) && (cand == PATTERN);

    always_comb begin
        hist_d      = hist_q;
        fill_d      = fill_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        det_valid_d = 1'b0;
        det_ch_d    = det_ch_q;
        if (engine == EngClear) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                hist_d[i] = '0;
                fill_d[i] = '0;
                cnt_d[i]  = '0;
            end
            ptr_d = '0;
        end else if (xfer) begin
            // History is never flushed on a match, giving overlapping detection
            hist_d[gnt_id] = cand[PAT_LEN-2:0];
            if (fill_q[gnt_id] != FILL_MAX) begin
                fill_d[gnt_id] = fill_q[gnt_id] + 1'b1;
            end
            ptr_d       = (gnt_id == CH_W'(NUM_CH - 1)) ? '0 : gnt_id + 1'b1;
            det_valid_d = match;
            if (match) begin
                det_ch_d = gnt_id;
                if (cnt_q[gnt_id] != '1) begin
                    cnt_d[gnt_id] = cnt_q[gnt_id] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            hist_q      <= '{default: '0};
            fill_q      <= '{default: '0};
            cnt_q       <= '{default: '0};
            ptr_q       <= '0;
            det_valid_q <= 1'b0;
            det_ch_q    <= '0;
        end else begin
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            det_valid_q <= det_valid_d;
            det_ch_q    <= det_ch_d;
        end
    end

    assign det_valid_o = det_valid_q;
    assign det_ch_o    = det_ch_q;

    always_comb begin
        match_cnt_o = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            match_cnt_o[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

endmodule

// File: tb/tb_seq_det_sched.sv
// Bench for seq_det_sched: instance A uses defaults (1011, 8-bit counters),
// instance B uses pattern 0010 with 2-bit counters. Both share the stimulus.
// A per-stream model (bit count + recent bits) is compared on every negedge.
module tb_seq_det_sched;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] valid = '0;
    logic [3:0] bits = '0;

    logic [3:0]  rdy_a, rdy_b;
    logic        dv_a, dv_b;
    logic [1:0]  dch_a, dch_b;
    logic [31:0] cnt_a;
    logic [7:0]  cnt_b;

    int errors = 0;
    int checks = 0;
    int pulses [2];

    // model state
    logic [3:0]  pat  [2];
    int          cmax [2];
    int          m_ptr [2];
    int          m_seen [2][4];
    logic [31:0] m_last [2][4];
    int          m_cnt [2][4];
    bit          m_dv [2];
    int          m_dch [2];

    always #5 clk = ~clk;

    seq_det_sched u_dut_a (
        .clk         (clk),
        .nrst        (nrst),
        .en_i        (en),
        .clr_i       (clr),
        .ch_valid_i  (valid),
        .ch_bit_i    (bits),
        .ch_ready_o  (rdy_a),
        .det_valid_o (dv_a),
        .det_ch_o    (dch_a),
        .match_cnt_o (cnt_a)
    );

    seq_det_sched #(
        .NUM_CH  (4),
        .PAT_LEN (4),
        .PATTERN (4'b0010),
        .CNT_W   (2)
    ) u_dut_b (
        .clk         (clk),
        .nrst        (nrst),
        .en_i        (en),
        .clr_i       (clr),
        .ch_valid_i  (valid),
        .ch_bit_i    (bits),
        .ch_ready_o  (rdy_b),
        .det_valid_o (dv_b),
        .det_ch_o    (dch_b),
        .match_cnt_o (cnt_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ptr[k] = 0;
            m_dv[k]  = 1'b0;
            m_dch[k] = 0;
            for (int j = 0; j < 4; j++) begin
                m_seen[k][j] = 0;
                m_last[k][j] = '0;
                m_cnt[k][j]  = 0;
            end
        end
    endtask

    always @(negedge nrst) model_reset();

    function automatic int act_cnt(input int k, input int j);
        return (k == 0) ? int'(cnt_a[j*8 +: 8]) : int'(cnt_b[j*2 +: 2]);
    endfunction

    // Compare process plus model advance; inputs are stable across this
    // negedge and the following posedge.
    always @(negedge clk) begin
        if (!nrst) begin
            chk("rst_rdy_a", int'(rdy_a), 0);
        end else begin
            for (int k = 0; k < 2; k++) begin
                int  eg;
                bit  hit;
                eg = -1;
                if (en && !clr) begin
                    for (int j = 0; j < 4; j++) begin
                        if (eg < 0 && valid[(m_ptr[k] + j) % 4]) eg = (m_ptr[k] + j) % 4;
                    end
                end
                chk($sformatf("rdy%0d", k), int'(k == 0 ? rdy_a : rdy_b),
                    (eg >= 0) ? (1 << eg) : 0);
                chk($sformatf("dv%0d", k), int'(k == 0 ? dv_a : dv_b), int'(m_dv[k]));
                chk($sformatf("dch%0d", k), int'(k == 0 ? dch_a : dch_b), m_dch[k]);
                for (int j = 0; j < 4; j++) begin
                    chk($sformatf("cnt%0d_ch%0d", k, j), act_cnt(k, j), m_cnt[k][j]);
                end
                if (k == 0 ? dv_a : dv_b) pulses[k]++;

                if (clr) begin
                    m_ptr[k] = 0;
                    m_dv[k]  = 1'b0;
                    for (int j = 0; j < 4; j++) begin
                        m_seen[k][j] = 0;
                        m_last[k][j] = '0;
                        m_cnt[k][j]  = 0;
                    end
                end else if (eg >= 0) begin
                    m_seen[k][eg]++;
                    m_last[k][eg] = {m_last[k][eg][30:0], bits[eg]};
                    hit = (m_seen[k][eg] >= 4) && (m_last[k][eg][3:0] == pat[k]);
                    m_dv[k] = hit;
                    if (hit) begin
                        m_dch[k] = eg;
                        if (m_cnt[k][eg] < cmax[k]) m_cnt[k][eg]++;
                    end
                    m_ptr[k] = (eg + 1) % 4;
                end else begin
                    m_dv[k] = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int ch, input bit b);
        valid = 4'(1 << ch);
        bits[ch] = b;
        tick();
        valid = '0;
    endtask

    task automatic send_str(input int ch, input string s);
        for (int i = 0; i < s.len(); i++) send(ch, s[i] == "1");
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        int p0, p1;
        logic [3:0] p2;
        pat[0] = 4'b1011; cmax[0] = 255;
        pat[1] = 4'b0010; cmax[1] = 3;
        pulses[0] = 0; pulses[1] = 0;
        model_reset();

        repeat (2) tick();
        chk("reset_rdy", int'(rdy_a), 0);
        chk("reset_dv", int'(dv_a), 0);
        chk("reset_cnt", int'(cnt_a), 0);
        nrst = 1'b1;
        en   = 1'b1;
        tick();

        // 1: overlapping matches on channel 0
        p0 = pulses[0];
        send_str(0, "1011011");
        repeat (2) tick();
        chk("t1_pulses", pulses[0] - p0, 2);
        chk("t1_cnt0", int'(cnt_a[7:0]), 2);
        chk("t1_dch", int'(dch_a), 0);

        // 2: all channels valid, strict rotation, pattern only on channel 2
        do_clr();
        p0 = pulses[0];
        p2 = 4'b1011;
        valid = 4'hf;
        for (int c = 0; c < 16; c++) begin
            bits = 4'b1011;
            bits[2] = p2[3 - c / 4];
            #1;
            chk("t2_gnt", int'(rdy_a), 1 << (c % 4));
            tick();
        end
        valid = '0;
        repeat (2) tick();
        chk("t2_pulses", pulses[0] - p0, 1);
        chk("t2_dch", int'(dch_a), 2);
        chk("t2_cnt", int'(cnt_a), 32'h0001_0000);

        // 3: channel 1 stalls mid-pattern while channel 3 streams ones
        do_clr();
        send_str(1, "101");
        for (int i = 0; i < 5; i++) begin
            valid = (i < 4) ? 4'b1000 : 4'b0000;
            bits[3] = 1'b1;
            tick();
        end
        valid = '0;
        send(1, 1'b1);
        repeat (2) tick();
        chk("t3_cnt1", int'(cnt_a[15:8]), 1);
        chk("t3_cnt3", int'(cnt_a[31:24]), 0);
        chk("t3_dch", int'(dch_a), 1);

        // 4: pattern 0010 -- no false match on fresh zero history
        do_clr();
        p1 = pulses[1];
        send_str(0, "010");
        repeat (2) tick();
        chk("t4_nofalse", pulses[1] - p1, 0);
        do_clr();
        p1 = pulses[1];
        send_str(0, "10010");
        repeat (2) tick();
        chk("t4_pulses", pulses[1] - p1, 1);
        chk("t4_cnt", int'(cnt_b[1:0]), 1);

        // 5: 2-bit counter saturates after four matches
        do_clr();
        p1 = pulses[1];
        send_str(0, "0010010010010");
        repeat (2) tick();
        chk("t5_pulses", pulses[1] - p1, 4);
        chk("t5_sat", int'(cnt_b[1:0]), 3);

        // 6: clear mid-pattern discards history and resets the pointer
        do_clr();
        p0 = pulses[0];
        send_str(0, "101");
        do_clr();
        valid = 4'hf;
        bits  = 4'b0001;
        #1;
        chk("t6_ptr0", int'(rdy_a), 1);
        tick();
        valid = '0;
        repeat (2) tick();
        chk("t6_nomatch", pulses[0] - p0, 0);
        chk("t6_cnt0", int'(cnt_a[7:0]), 0);

        // async reset mid-cycle right after a match completes
        do_clr();
        send_str(0, "101");
        valid = 4'b0001;
        bits  = 4'b0001;
        tick();
        valid = '0;
        chk("t6_pre_dv", int'(dv_a), 1);
        #1 nrst = 1'b0;
        #1;
        chk("t6_async_dv", int'(dv_a), 0);
        chk("t6_async_cnt", int'(cnt_a), 0);
        chk("t6_async_rdy", int'(rdy_a), 0);
        tick();
        nrst = 1'b1;
        p0 = pulses[0];
        send_str(0, "011");
        repeat (2) tick();
        chk("t6_hist_gone", pulses[0] - p0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
